frame_timing_gen: RTL and testbench
===================================

Name: frame_timing_gen

Overview:
Parametrised successor to the fixed NTSC/PAL frame timer. Generates horizontal and vertical sync, blank, border and viewport classification, byte-fetch strobes and character-row counts for the VDG pipeline, all from one pixel clock. Adds three things the fixed timer lacks: asynchronous reset, registered glitch-free outputs, and frame-atomic format and line-atomic width switching. It also supports 16/32/64-byte viewports. Sits between the pixel clock and the data fetch / char ROM / pixel serialiser blocks.

Parameters:
CW, 9, width of column and row counters
H_TOTAL, 458, pixel clocks per line
H_SYNC_START, 10, first column with hsn low
H_SYNC_END, 34, first column after the hsync pulse
H_BLANK_END, 78, first non-blanked column
PORT_X, 129, first viewport column
PORT_W, 256, viewport width in pixels
PRELOAD_LEAD, 8, number of clocks the first fetch precedes PORT_X
V_TOTAL0, 258, lines per frame for NTSC
V_TOTAL1, 311, lines per frame for PAL
V_SYNC_START, 3, first row with fsn low
V_SYNC_END, 8, first row after the vsync pulse
V_BLANK_END, 10, first non-blanked row
PORT_Y0, 63, first viewport row for NTSC
PORT_Y1, 88, first viewport row for PAL
PORT_H, 192, viewport height in rows
GLYPH_ROWS, 12, character cell height in rows

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous, active-low reset
format  in  1  0 = NTSC, 1 = PAL; sampled at frame start
width_sel  in  2  viewport bytes: 00 = 16, 01 = 32, 10 = 64, 11 = 32
hsn  out  1  horizontal sync, active low
fsn  out  1  vertical sync, active low
active  out  2  00 = blank, 10 = border, 11 = viewport
fetch  out  1  one-clock byte fetch strobe
preload  out  1  fetch strobe for byte 0 of a line
byte_index  out  6  index of the byte being fetched (valid with fetch)
alpha_count  out  4  char ROM row within the current cell
rowclear  out  1  high for the whole last row of a cell
frame_start  out  1  one-clock pulse at column 0, row 0
col  out  CW  column coordinate aligned with the other outputs
row  out  CW  row coordinate aligned with the other outputs

Behaviour:
- Counters: col counts 0..H_TOTAL-1 and wraps. row increments when col wraps, counts 0..V_TOTAL-1 and wraps.
- V_TOTAL and PORT_Y come from fmt_q. fmt_q latches format when col = H_TOTAL-1 and row = V_TOTAL-1, so a format change never splits a frame.
- Width: wsel_q latches width_sel when col = H_TOTAL-1. Value 11 is treated as 01.
- Output alignment: every output is a registered decode of the current counters. col, row and all other outputs change together, one clock after the counter value.
- Reset (resetn low, asynchronous, valid at any time including mid-line):
  - counters = 0, fmt_q = 0, wsel_q = 01
  - hsn = 1, fsn = 1, active = 00
  - fetch = 0, preload = 0, byte_index = 0, alpha_count = 0, rowclear = 0, frame_start = 0, col = 0, row = 0
- Counting restarts at (0,0) on the first clock after release. frame_start is asserted one clock later.
- Syncs:
  - hsn = 0 iff H_SYNC_START <= col < H_SYNC_END
  - fsn = 0 iff V_SYNC_START <= row < V_SYNC_END
- Region decode:
  - blank when col < H_BLANK_END or row < V_BLANK_END
  - viewport when PORT_X <= col < PORT_X+PORT_W and PORT_Y <= row < PORT_Y+PORT_H
  - border otherwise
  - blank takes priority over viewport.
- Fetch:
  - Bytes per line B = 16, 32 or 64; pixels per byte P = PORT_W/B = 16, 8 or 4.
  - On viewport rows only, fetch pulses at col = PORT_X - PRELOAD_LEAD + k*P for k = 0..B-1.
  - byte_index = k on each pulse and holds its last value otherwise.
  - preload = fetch && k == 0. No fetch on non-viewport rows.
- Char rows:
  - alpha_count = 0 on non-viewport rows.
  - On the first viewport row it is 0. It increments at each line wrap within the viewport and wraps GLYPH_ROWS-1 -> 0.
  - rowclear = viewport row && alpha_count == GLYPH_ROWS-1.
- Static parameter checks (elaboration error on violation):
  - PORT_X+PORT_W <= H_TOTAL
  - PORT_Y1+PORT_H <= V_TOTAL1
  - PORT_X >= PRELOAD_LEAD
  - PORT_W divisible by 64

Decomposition:
- frame_timing_pkg holds:
  - encodings ACTIVE_BLANK = 2'b00, ACTIVE_BORDER = 2'b10, ACTIVE_VIEW = 2'b11
  - width_sel encodings
  - the default timing constants for both formats
- One sub-module, frame_counter: col/row pair with a per-format row limit and async reset. It outputs col, row, line_wrap and frame_wrap.
- Decode, fetch and char-row logic stay in frame_timing_gen.

Test Plan:
- Reset release, NTSC, width 01: frame_start period 118164 clocks (458*258). hsn low for 24 clocks per line. fsn low on rows 3..7.
- format raised mid-frame: current frame still ends at row 257. Next frame is 311 rows; frame_start period 142438. Viewport rows become 88..279.
- width 01, viewport row: 32 fetches at cols 121, 129, …, 369. preload only at col 121. byte_index runs 0..31. width 10 gives 64 fetches every 4 cols. width 00 gives 16 fetches every 16 cols.
- NTSC, 16 cells of 12 rows: rowclear high on rows 74, 86, …, 254. alpha_count = 0 on rows 62 and 255.
- resetn pulsed low at col 200, row 100: outputs take their reset values immediately, without waiting for clk. After release, counting restarts at (0,0) and frame_start occurs one clock later.
- Row 5, col 20: active = 00, hsn = 0, fsn = 0. Col 129, row 63 (NTSC): active = 11. Col 385, row 63: active = 10.

Source files
------------

// File: rtl/frame_timing_pkg.sv
// rtl/frame_timing_pkg.sv - encodings and default NTSC/PAL timing for frame_timing_gen
package frame_timing_pkg;

  localparam logic [1:0] ACTIVE_BLANK  = 2'b00;
  localparam logic [1:0] ACTIVE_BORDER = 2'b10;
  localparam logic [1:0] ACTIVE_VIEW   = 2'b11;

  typedef enum logic [1:0] {
    WSEL_16  = 2'b00,
    WSEL_32  = 2'b01,
    WSEL_64  = 2'b10,
    WSEL_32B = 2'b11
  } wsel_t;

  localparam int DEF_CW           = 9;
  localparam int DEF_H_TOTAL      = 458;
  localparam int DEF_H_SYNC_START = 10;
  localparam int DEF_H_SYNC_END   = 34;
  localparam int DEF_H_BLANK_END  = 78;
  localparam int DEF_PORT_X       = 129;
  localparam int DEF_PORT_W       = 256;
  localparam int DEF_PRELOAD_LEAD = 8;
  localparam int DEF_V_TOTAL0     = 258;
  localparam int DEF_V_TOTAL1     = 311;
  localparam int DEF_V_SYNC_START = 3;
  localparam int DEF_V_SYNC_END   = 8;
  localparam int DEF_V_BLANK_END  = 10;
  localparam int DEF_PORT_Y0      = 63;
  localparam int DEF_PORT_Y1      = 88;
  localparam int DEF_PORT_H       = 192;
  localparam int DEF_GLYPH_ROWS   = 12;

  // The spare code 11 is an alias of the 32-byte mode.
  function automatic wsel_t normWsel(input logic [1:0] raw);
    return (raw == 2'b11) ? WSEL_32 : wsel_t'(raw);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - column/row counter pair with a per-format row limit
module frame_counter
  import frame_timing_pkg::*;
#(
  parameter int CW      = DEF_CW,
  parameter int H_TOTAL = DEF_H_TOTAL
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [CW-1:0] rowLimit,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          line_wrap,
  output logic          frame_wrap
);

  localparam logic [CW-1:0] LAST_COL = CW'(H_TOTAL - 1);

  assign line_wrap  = (col == LAST_COL);
  assign frame_wrap = line_wrap && (row == rowLimit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (line_wrap) begin
      col <= '0;
      row <= frame_wrap ? '0 : row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

endmodule

// File: rtl/frame_timing_gen.sv
// rtl/frame_timing_gen.sv - registered sync, region, fetch and char-row decode for the VDG
module frame_timing_gen
  import frame_timing_pkg::*;
#(
  parameter int CW           = DEF_CW,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int H_BLANK_END  = DEF_H_BLANK_END,
  parameter int PORT_X       = DEF_PORT_X,
  parameter int PORT_W       = DEF_PORT_W,
  parameter int PRELOAD_LEAD = DEF_PRELOAD_LEAD,
  parameter int V_TOTAL0     = DEF_V_TOTAL0,
  parameter int V_TOTAL1     = DEF_V_TOTAL1,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END,
  parameter int V_BLANK_END  = DEF_V_BLANK_END,
  parameter int PORT_Y0      = DEF_PORT_Y0,
  parameter int PORT_Y1      = DEF_PORT_Y1,
  parameter int PORT_H       = DEF_PORT_H,
  parameter int GLYPH_ROWS   = DEF_GLYPH_ROWS
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          format,
  input  logic [1:0]    width_sel,
  output logic          hsn,
  output logic          fsn,
  output logic [1:0]    active,
  output logic          fetch,
  output logic          preload,
  output logic [5:0]    byte_index,
  output logic [3:0]    alpha_count,
  output logic          rowclear,
  output logic          frame_start,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row
);

  if (PORT_X + PORT_W > H_TOTAL) begin : gBadPortX
    $error("viewport exceeds line length");
  end
  if (PORT_Y1 + PORT_H > V_TOTAL1) begin : gBadPortY
    $error("viewport exceeds PAL frame height");
  end
  if (PORT_X < PRELOAD_LEAD) begin : gBadLead
    $error("preload lead exceeds viewport start");
  end
  if (PORT_W % 64 != 0) begin : gBadWidth
    $error("viewport width must be a multiple of 64");
  end

  localparam logic [CW-1:0] HS_ON      = CW'(H_SYNC_START);
  localparam logic [CW-1:0] HS_OFF     = CW'(H_SYNC_END);
  localparam logic [CW-1:0] HB_END     = CW'(H_BLANK_END);
  localparam logic [CW-1:0] VIEW_X0    = CW'(PORT_X);
  localparam logic [CW-1:0] VIEW_X1    = CW'(PORT_X + PORT_W);
  localparam logic [CW-1:0] FETCH_X    = CW'(PORT_X - PRELOAD_LEAD);
  localparam logic [CW-1:0] FETCH_SPAN = CW'(PORT_W);
  localparam logic [CW-1:0] VS_ON      = CW'(V_SYNC_START);
  localparam logic [CW-1:0] VS_OFF     = CW'(V_SYNC_END);
  localparam logic [CW-1:0] VB_END     = CW'(V_BLANK_END);
  localparam int            SH16       = $clog2(PORT_W / 16);
  localparam int            SH32       = $clog2(PORT_W / 32);
  localparam int            SH64       = $clog2(PORT_W / 64);
  localparam logic [3:0]    LAST_GLYPH = 4'(GLYPH_ROWS - 1);

  logic          fmtQ;
  wsel_t         wselQ;
  logic [3:0]    alphaCnt;
  logic [CW-1:0] cntCol, cntRow, rowLimit, portY, portYEnd;
  logic          lineWrap, frameWrap;

  assign rowLimit = fmtQ ? CW'(V_TOTAL1 - 1) : CW'(V_TOTAL0 - 1);
  assign portY    = fmtQ ? CW'(PORT_Y1) : CW'(PORT_Y0);
  assign portYEnd = fmtQ ? CW'(PORT_Y1 + PORT_H) : CW'(PORT_Y0 + PORT_H);

  frame_counter #(.CW(CW), .H_TOTAL(H_TOTAL)) uCounter (
    .clk        (clk),
    .resetn     (resetn),
    .rowLimit   (rowLimit),
    .col        (cntCol),
    .row        (cntRow),
    .line_wrap  (lineWrap),
    .frame_wrap (frameWrap)
  );

  logic          hSync, vSync, blank, viewRow, viewCol, lastViewRow, fetchHit;
  logic [1:0]    activeNext;
  logic [CW-1:0] fetchOff, stepMask;
  int            stepShift;
  logic [5:0]    byteNext;

  always_comb begin
    stepShift = SH32;
    stepMask  = CW'((1 << SH32) - 1);
    case (wselQ)
      WSEL_16: begin stepShift = SH16; stepMask = CW'((1 << SH16) - 1); end
      WSEL_64: begin stepShift = SH64; stepMask = CW'((1 << SH64) - 1); end
      default: ;
    endcase
    hSync       = (cntCol >= HS_ON) && (cntCol < HS_OFF);
    vSync       = (cntRow >= VS_ON) && (cntRow < VS_OFF);
    blank       = (cntCol < HB_END) || (cntRow < VB_END);
    viewRow     = (cntRow >= portY) && (cntRow < portYEnd);
    viewCol     = (cntCol >= VIEW_X0) && (cntCol < VIEW_X1);
    lastViewRow = (cntRow == portYEnd - 1'b1);
    activeNext  = blank ? ACTIVE_BLANK : ((viewRow && viewCol) ? ACTIVE_VIEW : ACTIVE_BORDER);
    // Fetch slots start PRELOAD_LEAD clocks ahead of the viewport, one per byte period.
    fetchOff    = cntCol - FETCH_X;
    fetchHit    = viewRow && (cntCol >= FETCH_X) && (fetchOff < FETCH_SPAN)
                  && ((fetchOff & stepMask) == '0);
    byteNext    = 6'(fetchOff >> stepShift);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fmtQ     <= 1'b0;
      wselQ    <= WSEL_32;
      alphaCnt <= '0;
    end else begin
      if (frameWrap) fmtQ <= format;
      if (lineWrap) begin
        wselQ    <= normWsel(width_sel);
        alphaCnt <= (viewRow && !lastViewRow)
                    ? ((alphaCnt == LAST_GLYPH) ? '0 : alphaCnt + 1'b1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsn         <= 1'b1;
      fsn         <= 1'b1;
      active      <= ACTIVE_BLANK;
      fetch       <= 1'b0;
      preload     <= 1'b0;
      byte_index  <= '0;
      alpha_count <= '0;
      rowclear    <= 1'b0;
      frame_start <= 1'b0;
      col         <= '0;
      row         <= '0;
    end else begin
      hsn         <= !hSync;
      fsn         <= !vSync;
      active      <= activeNext;
      fetch       <= fetchHit;
      preload     <= fetchHit && (byteNext == '0);
      if (fetchHit) byte_index <= byteNext;
      alpha_count <= alphaCnt;
      rowclear    <= viewRow && (alphaCnt == LAST_GLYPH);
      frame_start <= (cntCol == '0) && (cntRow == '0);
      col         <= cntCol;
      row         <= cntRow;
    end
  end

endmodule

// File: tb/tb_frame_timing_gen.sv
// tb/tb_frame_timing_gen.sv - directed self-checking bench for frame_timing_gen
module tb_frame_timing_gen;

  localparam int HT = 458;

  logic       clk = 1'b0;
  logic       resetn = 1'b0, resetnS = 1'b0;
  logic       format = 1'b0, formatS = 1'b0;
  logic [1:0] width_sel = 2'b01;
  logic [1:0] widthS = 2'b01;

  logic       hsn, fsn, fetch, preload, rowclear, frame_start;
  logic [1:0] active;
  logic [5:0] byte_index;
  logic [3:0] alpha_count;
  logic [8:0] col, row;

  logic       hsnS, fsnS, fetchS, preloadS, rowclearS, frameStartS;
  logic [1:0] activeS;
  logic [5:0] byteIndexS;
  logic [3:0] alphaS;
  logic [8:0] colS, rowS;

  int nCmp = 0;
  int nBad = 0;
  int pos  = 0;

  always #5 clk = ~clk;

  frame_timing_gen dut (
    .clk(clk), .resetn(resetn), .format(format), .width_sel(width_sel),
    .hsn(hsn), .fsn(fsn), .active(active), .fetch(fetch), .preload(preload),
    .byte_index(byte_index), .alpha_count(alpha_count), .rowclear(rowclear),
    .frame_start(frame_start), .col(col), .row(row)
  );

  // Shrunken timing so whole frames and a format switch fit in a short run.
  frame_timing_gen #(
    .H_TOTAL(80), .H_SYNC_START(2), .H_SYNC_END(6), .H_BLANK_END(8),
    .PORT_X(12), .PORT_W(64), .PRELOAD_LEAD(4),
    .V_TOTAL0(20), .V_TOTAL1(26), .V_SYNC_START(1), .V_SYNC_END(2), .V_BLANK_END(3),
    .PORT_Y0(5), .PORT_Y1(8), .PORT_H(12), .GLYPH_ROWS(12)
  ) dutS (
    .clk(clk), .resetn(resetnS), .format(formatS), .width_sel(widthS),
    .hsn(hsnS), .fsn(fsnS), .active(activeS), .fetch(fetchS), .preload(preloadS),
    .byte_index(byteIndexS), .alpha_count(alphaS), .rowclear(rowclearS),
    .frame_start(frameStartS), .col(colS), .row(rowS)
  );

  task automatic checkVal(input string tag, input int got, input int exp);
    nCmp++;
    if (got != exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
    pos += n;
  endtask

  task automatic gotoRC(input int c, input int r);
    advance(r * HT + c - pos);
    checkVal("pos_col", int'(col), c);
    checkVal("pos_row", int'(row), r);
  endtask

  task automatic waitFrameS(output int n, input int raiseAt);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (n == raiseAt) formatS = 1'b1;
      if (frameStartS) break;
    end
  endtask

  // Starts at column 0 of row r; width for the following row is set at once.
  task automatic scanLine(input int r, input int nb, input int stride, input logic [1:0] nextW);
    int nF, nP, pCol, lastCol, badSeq;
    nF = 0; nP = 0; pCol = -1; lastCol = -1; badSeq = 0;
    width_sel = nextW;
    for (int c = 0; c < HT; c++) begin
      if (c == 128) checkVal("edge_128", int'(active), 2);
      if (c == 129) checkVal("edge_129", int'(active), 3);
      if (c == 384) checkVal("edge_384", int'(active), 3);
      if (c == 385) checkVal("edge_385", int'(active), 2);
      if (preload) begin nP++; pCol = int'(col); end
      if (fetch) begin
        if (int'(col) != 121 + nF * stride || int'(byte_index) != nF) badSeq++;
        lastCol = int'(col);
        nF++;
      end
      advance(1);
    end
    checkVal($sformatf("nfetch_r%0d", r), nF, nb);
    checkVal($sformatf("npreload_r%0d", r), nP, 1);
    checkVal($sformatf("preload_col_r%0d", r), pCol, 121);
    checkVal($sformatf("last_fetch_r%0d", r), lastCol, 121 + (nb - 1) * stride);
    checkVal($sformatf("fetch_seq_r%0d", r), badSeq, 0);
    checkVal($sformatf("idx_hold_r%0d", r), int'(byte_index), nb - 1);
  endtask

  initial begin
    int per, lowCnt, firstLow;

    repeat (3) @(negedge clk);
    checkVal("rst_hsn", int'(hsn), 1);
    checkVal("rst_fsn", int'(fsn), 1);
    checkVal("rst_active", int'(active), 0);
    checkVal("rst_fetch_pre", int'({fetch, preload}), 0);
    checkVal("rst_idx", int'(byte_index), 0);
    checkVal("rst_alpha_rc", int'({alpha_count, rowclear}), 0);
    checkVal("rst_fs", int'(frame_start), 0);
    checkVal("rst_colrow", int'({col, row}), 0);

    resetnS = 1'b1;
    waitFrameS(per, -1);
    checkVal("s_first_fs", per, 1);
    waitFrameS(per, -1);
    checkVal("s_ntsc_period", per, 1600);
    waitFrameS(per, 700);
    checkVal("s_switch_frame", per, 1600);
    waitFrameS(per, -1);
    checkVal("s_pal_period", per, 2080);
    repeat (7 * 80 + 12) @(negedge clk);
    checkVal("s_pal_row7", int'(activeS), 2);
    repeat (80) @(negedge clk);
    checkVal("s_pal_row8", int'(activeS), 3);

    resetn = 1'b1;
    @(negedge clk);
    pos = 0;
    checkVal("fs_first", int'(frame_start), 1);
    checkVal("fs_col", int'(col), 0);
    advance(1);
    checkVal("fs_drop", int'(frame_start), 0);

    lowCnt = 0; firstLow = -1;
    for (int c = 1; c < HT; c++) begin
      if (!hsn) begin
        lowCnt++;
        if (firstLow < 0) firstLow = int'(col);
      end
      advance(1);
    end
    checkVal("hsn_width", lowCnt, 24);
    checkVal("hsn_start", firstLow, 10);

    gotoRC(0, 2);   checkVal("fsn_r2", int'(fsn), 1);
    gotoRC(0, 3);   checkVal("fsn_r3", int'(fsn), 0);
    gotoRC(20, 5);
    checkVal("r5_active", int'(active), 0);
    checkVal("r5_hsn", int'(hsn), 0);
    checkVal("r5_fsn", int'(fsn), 0);
    gotoRC(457, 7); checkVal("fsn_r7", int'(fsn), 0);
    gotoRC(0, 8);   checkVal("fsn_r8", int'(fsn), 1);
    gotoRC(100, 9); checkVal("blank_r9", int'(active), 0);
    gotoRC(100, 10); checkVal("border_r10", int'(active), 2);
    gotoRC(129, 62);
    checkVal("r62_active", int'(active), 2);
    checkVal("r62_alpha", int'(alpha_count), 0);
    gotoRC(0, 63);
    checkVal("r63_idx_idle", int'(byte_index), 0);
    checkVal("r63_alpha", int'(alpha_count), 0);

    scanLine(63, 32, 8, 2'b10);
    scanLine(64, 64, 4, 2'b00);
    scanLine(65, 16, 16, 2'b11);

    gotoRC(0, 73);
    checkVal("r73_rowclear", int'(rowclear), 0);
    checkVal("r73_alpha", int'(alpha_count), 10);
    gotoRC(0, 74);
    checkVal("r74_rowclear", int'(rowclear), 1);
    checkVal("r74_alpha", int'(alpha_count), 11);
    gotoRC(457, 74); checkVal("r74_rc_end", int'(rowclear), 1);
    gotoRC(0, 75);
    checkVal("r75_rowclear", int'(rowclear), 0);
    checkVal("r75_alpha", int'(alpha_count), 0);
    gotoRC(0, 86);  checkVal("r86_rowclear", int'(rowclear), 1);

    gotoRC(200, 100);
    checkVal("r100_active", int'(active), 3);
    checkVal("r100_idx", int'(byte_index), 9);
    checkVal("r100_alpha", int'(alpha_count), 1);

    resetn = 1'b0;
    #1;
    checkVal("arst_colrow", int'({col, row}), 0);
    checkVal("arst_idx", int'(byte_index), 0);
    checkVal("arst_active", int'(active), 0);
    checkVal("arst_alpha", int'(alpha_count), 0);
    checkVal("arst_syncs", int'({hsn, fsn}), 3);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    pos = 0;
    checkVal("rel_fs", int'(frame_start), 1);
    checkVal("rel_colrow", int'({col, row}), 0);
    advance(1);
    checkVal("rel_col1", int'(col), 1);
    checkVal("rel_fs_drop", int'(frame_start), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
